ws2812b_chain_capture: RTL and testbench

Parametrised WS2812B chain-tap peripheral for the TinyQV byte-peripheral slot, successor to the single-LED sniffer. It decodes the raw WS2812B input and captures the first `NUM_LEDS` LEDs of each frame (3 or 4 bytes per LED) into a double-buffered register file. It forwards the remainder of the frame on `dout`, exactly as a physical LED chain segment of that length would. Each completed frame is committed atomically at latch time, with ready, overrun, short-frame and freeze control for the CPU.

---
 rtl/ws2812b_pkg.sv | 39 +++
 rtl/ws2812b_chain_capture_bit_decoder.sv | 85 ++++++++
 rtl/ws2812b_chain_capture.sv | 218 +++++++++++++++++++++
 tb/tb_ws2812b_chain_capture.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ws2812b_pkg
// Description : Shared types and constants for the WS2812B chain-tap
//               peripheral: FSM state encoding, latch-time helper,
//               status-bit positions and register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812b_pkg;

    // Frame-level capture state
    typedef enum logic [1:0] {
        ST_WAIT_LATCH = 2'd0,
        ST_CAPTURE    = 2'd1,
        ST_PASS       = 2'd2
    } state_t;

    // Bit positions inside the status register
    localparam int STAT_READY   = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_SHORT   = 2;
    localparam int STAT_BUSY    = 3;

    // Bit positions inside the control register
    localparam int CTRL_FREEZE  = 0;
    localparam int CTRL_CLEAR   = 1;

    // Register addresses
    localparam logic [3:0] ADDR_CTRL   = 4'hE;
    localparam logic [3:0] ADDR_STATUS = 4'hF;

    // Number of clock cycles of continuous low that marks a latch
    function automatic int calc_idle_cycles(input int clk_hz, input int idle_us);
        return (clk_hz / 1000000) * idle_us;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812b_chain_capture_bit_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ws2812b_bit_decoder
// Description : Turns the raw WS2812B waveform into decoded bits and a
//               single-cycle latch (idle) pulse. A bit is produced on each
//               falling edge, its value set by the preceding high time.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_bit_decoder #(
    parameter int THRESHOLD_CYCLES = 38,
    parameter int IDLE_CYCLES      = 3840
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic bit_valid,
    output logic bit_value,
    output logic idle
);

    localparam int             LOW_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(IDLE_CYCLES);
    localparam logic [LOW_W-1:0] LOW_PRE = LOW_W'(IDLE_CYCLES - 1);

    logic             din_prev_q,  din_prev_d;
    logic [7:0]       high_cnt_q,  high_cnt_d;
    logic [LOW_W-1:0] low_cnt_q,   low_cnt_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_value_q, bit_value_d;
    logic             idle_q,      idle_d;
    logic             fall;

    // Edge detect, saturating pulse-width counters and decoded bit/latch
    always_comb begin
        fall        = din_prev_q & ~din;
        din_prev_d  = din;
        bit_valid_d = fall;
        bit_value_d = bit_value_q;
        if (fall) begin
            bit_value_d = (int'(high_cnt_q) > THRESHOLD_CYCLES);
        end

        if (din) begin
            high_cnt_d = (high_cnt_q == 8'hFF) ? high_cnt_q : high_cnt_q + 8'd1;
        end else begin
            high_cnt_d = 8'd0;
        end

        // Low counter parks at IDLE_CYCLES so the latch fires only once
        if (din) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end else begin
            low_cnt_d = low_cnt_q;
        end
        idle_d = ~din && (low_cnt_q == LOW_PRE);
    end

    // Decoder state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_prev_q  <= 1'b0;
            high_cnt_q  <= 8'd0;
            low_cnt_q   <= '0;
            bit_valid_q <= 1'b0;
            bit_value_q <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            din_prev_q  <= din_prev_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_valid_q <= bit_valid_d;
            bit_value_q <= bit_value_d;
            idle_q      <= idle_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_value = bit_value_q;
    assign idle      = idle_q;

endmodule
`default_nettype wire

// File: rtl/ws2812b_chain_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ws2812b_chain_capture
// Description : WS2812B chain tap. Captures the first NUM_LEDS LEDs of every
//               frame into a shadow buffer, forwards the rest on dout like a
//               real LED segment, and commits completed frames atomically to
//               a CPU-visible buffer at latch time.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_chain_capture #(
    parameter int CLK_HZ           = 64000000,
    parameter int THRESHOLD_CYCLES = 38,
    parameter int IDLE_US          = 60,
    parameter int NUM_LEDS         = 4,
    parameter int BYTES_PER_LED    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       dout,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    import ws2812b_pkg::*;

    localparam int         IDLE_CYCLES = calc_idle_cycles(CLK_HZ, IDLE_US);
    localparam int         TOTAL       = NUM_LEDS * BYTES_PER_LED;
    localparam logic [3:0] LAST_IDX    = 4'(TOTAL - 1);

    generate
        if (TOTAL > 14 || TOTAL < 1) begin : g_bad_geometry
            $error("ws2812b_chain_capture: NUM_LEDS*BYTES_PER_LED must be 1..14");
        end
    endgenerate

    logic bit_valid, bit_value, idle;

    ws2812b_bit_decoder #(
        .THRESHOLD_CYCLES (THRESHOLD_CYCLES),
        .IDLE_CYCLES      (IDLE_CYCLES)
    ) u_decoder (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .bit_valid (bit_valid),
        .bit_value (bit_value),
        .idle      (idle)
    );

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shift_q, shift_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic [TOTAL*8-1:0] shadow_q, shadow_d;
    logic [TOTAL*8-1:0] visible_q, visible_d;
    logic               freeze_q, freeze_d;
    logic               ready_q, ready_d;
    logic               overrun_q, overrun_d;
    logic               short_q, short_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;
    logic               dout_q, dout_d;

    logic               in_capture, in_pass, commit, short_evt, busy;
    logic               byte_done;
    logic [7:0]         byte_value;
    logic               ctrl_wr, stat_wr;
    logic               unused_data_bits;

    assign unused_data_bits = ^data_in[7:2];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT_LATCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: latch opens a frame, last captured byte starts pass-through
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LATCH: if (idle) state_d = ST_CAPTURE;
            ST_CAPTURE:    if (byte_done && byte_idx_q == LAST_IDX) state_d = ST_PASS;
            ST_PASS:       if (idle) state_d = ST_CAPTURE;
            default:       state_d = ST_WAIT_LATCH;
        endcase
    end

    // FSM outputs: frame events derived from the current state
    always_comb begin
        in_capture = (state_q == ST_CAPTURE);
        in_pass    = (state_q == ST_PASS);
        commit     = in_pass & idle & ~freeze_q;
        short_evt  = in_capture & idle & (byte_idx_q != 4'd0);
        busy       = in_capture & (byte_idx_q != 4'd0);
        byte_done  = in_capture & ~idle & bit_valid & (bit_cnt_q == 3'd7);
        byte_value = {shift_q, bit_value};
    end

    // Byte assembly (MSB first) and shadow-buffer writes during capture
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        shadow_d   = shadow_q;
        if (!in_capture || idle) begin
            bit_cnt_d  = 3'd0;
            byte_idx_d = 4'd0;
        end else if (bit_valid) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[5:0], bit_value};
            if (byte_done) begin
                byte_idx_d = byte_idx_q + 4'd1;
                for (int i = 0; i < TOTAL; i++) begin
                    if (byte_idx_q == 4'(i)) begin
                        shadow_d[i*8 +: 8] = byte_value;
                    end
                end
            end
        end
    end

    // Register-map updates; a commit overrides a same-cycle buffer clear
    always_comb begin
        ctrl_wr     = data_write && (address == ADDR_CTRL);
        stat_wr     = data_write && (address == ADDR_STATUS);
        freeze_d    = freeze_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        short_d     = short_q;
        frame_cnt_d = frame_cnt_q;
        visible_d   = visible_q;

        if (ctrl_wr) begin
            freeze_d = data_in[CTRL_FREEZE];
            if (data_in[CTRL_CLEAR]) begin
                visible_d   = '0;
                frame_cnt_d = 4'd0;
            end
        end
        if (stat_wr) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
            short_d   = 1'b0;
        end
        if (short_evt) begin
            short_d = 1'b1;
        end
        if (commit) begin
            visible_d   = shadow_q;
            ready_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 4'd1;
            // A status write in the same cycle consumes the previous frame
            if (ready_q && !stat_wr) begin
                overrun_d = 1'b1;
            end
        end
        dout_d = din & in_pass;
    end

    // Datapath and register-file state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            byte_idx_q  <= 4'd0;
            shadow_q    <= '0;
            visible_q   <= '0;
            freeze_q    <= 1'b0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            short_q     <= 1'b0;
            frame_cnt_q <= 4'd0;
            dout_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            shadow_q    <= shadow_d;
            visible_q   <= visible_d;
            freeze_q    <= freeze_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            short_q     <= short_d;
            frame_cnt_q <= frame_cnt_d;
            dout_q      <= dout_d;
        end
    end

    assign dout = dout_q;

    // Combinational register read
    always_comb begin
        data_out = 8'h00;
        for (int i = 0; i < TOTAL; i++) begin
            if (address == 4'(i)) begin
                data_out = visible_q[i*8 +: 8];
            end
        end
        if (address == ADDR_CTRL) begin
            data_out[CTRL_FREEZE] = freeze_q;
        end
        if (address == ADDR_STATUS) begin
            data_out[STAT_READY]   = ready_q;
            data_out[STAT_OVERRUN] = overrun_q;
            data_out[STAT_SHORT]   = short_q;
            data_out[STAT_BUSY]    = busy;
            data_out[7:4]          = frame_cnt_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_chain_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ws2812b_chain_capture
// Description : Scoreboard bench for the WS2812B chain tap. Stimulus queues
//               expected register reads and forwarded pulse widths; monitors
//               pop and compare whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812b_chain_capture;

    localparam int IDLE_A = 3840;   // 64 MHz, 60 us
    localparam int IDLE_B = 640;    // 64 MHz, 10 us
    localparam int T0H    = 16;
    localparam int T1H    = 46;
    localparam int TL     = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_a = 1'b0, din_b = 1'b0;
    logic       dout_a, dout_b;
    logic [3:0] addr_a = 4'd0, addr_b = 4'd0;
    logic       wr_a = 1'b0, wr_b = 1'b0;
    logic [7:0] wdata_a = 8'd0, wdata_b = 8'd0;
    logic [7:0] rdata_a, rdata_b;

    always #8 clk = ~clk;

    ws2812b_chain_capture u_dut_a (
        .clk(clk), .reset(reset), .din(din_a), .dout(dout_a),
        .address(addr_a), .data_write(wr_a), .data_in(wdata_a), .data_out(rdata_a)
    );

    ws2812b_chain_capture #(
        .IDLE_US(10), .NUM_LEDS(3), .BYTES_PER_LED(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .din(din_b), .dout(dout_b),
        .address(addr_b), .data_write(wr_b), .data_in(wdata_b), .data_out(rdata_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        bit         is_dout;
        logic [7:0] exp;
        string      name;
    } rd_t;

    rd_t  rd_q[$];
    int   pulse_q_a[$];
    int   pulse_q_b[$];
    logic rd_strobe = 1'b0;
    rd_t        mon_e;
    logic [7:0] mon_act;
    int   hw_a = 0, hw_b = 0;

    // Read monitor: compares the presented value against the queued expectation
    always @(negedge clk) begin
        if (rd_strobe) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: read presented with no expected entry");
            end else begin
                mon_e = rd_q.pop_front();
                if (mon_e.is_dout) mon_act = {7'd0, (mon_e.sel != 0) ? dout_b : dout_a};
                else               mon_act = (mon_e.sel != 0) ? rdata_b : rdata_a;
                if (mon_act !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%02h expected 0x%02h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic pulse_check(input int sel, input int width);
        int e;
        checks++;
        if ((sel == 0 && pulse_q_a.size() == 0) || (sel != 0 && pulse_q_b.size() == 0)) begin
            errors++;
            $display("FAIL dout%0d_unexpected: pulse of %0d cycles, expected none", sel, width);
        end else begin
            e = (sel == 0) ? pulse_q_a.pop_front() : pulse_q_b.pop_front();
            if (width < e - 1 || width > e + 1) begin
                errors++;
                $display("FAIL dout%0d_width: got %0d cycles expected %0d", sel, width, e);
            end
        end
    endtask

    // Forwarded-pulse monitors: measure each dout high time
    always @(negedge clk) begin
        if (dout_a === 1'b1) hw_a++;
        else begin
            if (hw_a != 0) pulse_check(0, hw_a);
            hw_a = 0;
        end
    end

    always @(negedge clk) begin
        if (dout_b === 1'b1) hw_b++;
        else begin
            if (hw_b != 0) pulse_check(1, hw_b);
            hw_b = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int sel, input logic v);
        if (sel == 0) din_a = v; else din_b = v;
    endtask

    task automatic send_bit(input int sel, input logic v, input bit fwd);
        int h;
        h = v ? T1H : T0H;
        if (fwd) begin
            if (sel == 0) pulse_q_a.push_back(h); else pulse_q_b.push_back(h);
        end
        set_din(sel, 1'b1);
        repeat (h) tick();
        set_din(sel, 1'b0);
        repeat (TL) tick();
    endtask

    // LED n carries G=(base+n)*0x11, R=~G, B=0xA5, W=0x3C
    task automatic send_frame(input int sel, input int nleds, input int base,
                              input int fwd_from, input int bpl, input int max_bits);
        logic [7:0] led [4];
        int sent;
        sent = 0;
        for (int n = 0; n < nleds; n++) begin
            led[0] = 8'((base + n) * 17);
            led[1] = ~led[0];
            led[2] = 8'hA5;
            led[3] = 8'h3C;
            for (int k = 0; k < bpl; k++) begin
                for (int b = 7; b >= 0; b--) begin
                    if (max_bits >= 0 && sent >= max_bits) return;
                    send_bit(sel, led[k][b], n >= fwd_from);
                    sent++;
                end
            end
        end
    endtask

    task automatic latch(input int sel, input int n);
        set_din(sel, 1'b0);
        repeat (n) tick();
    endtask

    task automatic rd(input int sel, input logic [3:0] a, input logic [7:0] exp, input string name);
        rd_t e;
        e.sel = sel; e.is_dout = 1'b0; e.exp = exp; e.name = name;
        rd_q.push_back(e);
        if (sel == 0) addr_a = a; else addr_b = a;
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic chk_dout(input int sel, input logic exp, input string name);
        rd_t e;
        e.sel = sel; e.is_dout = 1'b1; e.exp = {7'd0, exp}; e.name = name;
        rd_q.push_back(e);
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [3:0] a, input logic [7:0] d);
        if (sel == 0) begin addr_a = a; wdata_a = d; wr_a = 1'b1; end
        else          begin addr_b = a; wdata_b = d; wr_b = 1'b1; end
        tick();
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        rd(0, 4'h0, 8'h00, "reset_addr0");
        rd(0, 4'h5, 8'h00, "reset_addr5");
        rd(0, 4'hE, 8'h00, "reset_ctrl");
        rd(0, 4'hF, 8'h00, "reset_status");
        chk_dout(0, 1'b0, "reset_dout");

        // Frame 1: 6 LEDs, LEDs 4-5 forwarded
        latch(0, IDLE_A + 20);
        rd(0, 4'hF, 8'h00, "first_latch_status");
        send_frame(0, 6, 0, 4, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'h0, 8'h00, "f1_addr0");
        rd(0, 4'h1, 8'hFF, "f1_addr1");
        rd(0, 4'h2, 8'hA5, "f1_addr2");
        rd(0, 4'h3, 8'h11, "f1_addr3");
        rd(0, 4'h9, 8'h33, "f1_addr9");
        rd(0, 4'hA, 8'hCC, "f1_addr10");
        rd(0, 4'hB, 8'hA5, "f1_addr11");
        rd(0, 4'hC, 8'h00, "f1_addr12");
        rd(0, 4'hD, 8'h00, "f1_addr13");
        rd(0, 4'hF, 8'h11, "f1_status");

        // Short frame
        send_frame(0, 2, 8, 99, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'hF, 8'h15, "short_status");
        rd(0, 4'h0, 8'h00, "short_addr0");
        rd(0, 4'h3, 8'h11, "short_addr3");
        wr(0, 4'hF, 8'h00);
        rd(0, 4'hF, 8'h10, "clear_status");

        // Frame A, then frame B committed together with a status write
        send_frame(0, 4, 1, 99, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'hF, 8'h21, "frameA_status");
        rd(0, 4'h0, 8'h11, "frameA_addr0");
        send_frame(0, 4, 2, 99, 3, -1);
        repeat (IDLE_A - TL) tick();
        wr(0, 4'hF, 8'h00);
        latch(0, 20);
        rd(0, 4'hF, 8'h31, "simul_status");
        rd(0, 4'h0, 8'h22, "frameB_addr0");

        // Frame C with ready still set -> overrun
        send_frame(0, 4, 3, 99, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'hF, 8'h43, "overrun_status");
        rd(0, 4'h1, 8'hCC, "frameC_addr1");
        wr(0, 4'hF, 8'h00);
        rd(0, 4'hF, 8'h40, "overrun_cleared");

        // Freeze drops a frame; clear zeroes buffer and frame count
        wr(0, 4'hE, 8'h01);
        rd(0, 4'hE, 8'h01, "freeze_ctrl");
        send_frame(0, 4, 6, 99, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'hF, 8'h40, "freeze_status");
        rd(0, 4'h0, 8'h33, "freeze_addr0");
        wr(0, 4'hE, 8'h02);
        rd(0, 4'hE, 8'h00, "clear_ctrl");
        rd(0, 4'h0, 8'h00, "clear_addr0");
        rd(0, 4'h1, 8'h00, "clear_addr1");
        rd(0, 4'hB, 8'h00, "clear_addr11");
        rd(0, 4'hF, 8'h00, "clear_cnt_status");

        // Reset mid-frame after 17 bits
        wr(0, 4'hE, 8'h01);
        send_frame(0, 4, 7, 99, 3, 17);
        rd(0, 4'hF, 8'h08, "busy_status");
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rd(0, 4'hF, 8'h00, "midreset_status");
        rd(0, 4'hE, 8'h00, "midreset_ctrl");
        rd(0, 4'h0, 8'h00, "midreset_addr0");
        chk_dout(0, 1'b0, "midreset_dout");
        send_frame(0, 1, 9, 99, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'hF, 8'h00, "ignored_bits_status");
        rd(0, 4'h0, 8'h00, "ignored_bits_addr0");
        send_frame(0, 4, 10, 99, 3, -1);
        latch(0, IDLE_A + 20);
        rd(0, 4'h0, 8'hAA, "post_reset_addr0");
        rd(0, 4'h1, 8'h55, "post_reset_addr1");
        rd(0, 4'h2, 8'hA5, "post_reset_addr2");
        rd(0, 4'h9, 8'hDD, "post_reset_addr9");
        rd(0, 4'hA, 8'h22, "post_reset_addr10");
        rd(0, 4'hF, 8'h11, "post_reset_status");

        // GRBW build: 3 LEDs captured, 4th forwarded
        latch(1, IDLE_B + 20);
        send_frame(1, 4, 0, 3, 4, -1);
        latch(1, IDLE_B + 20);
        rd(1, 4'h0, 8'h00, "grbw_addr0");
        rd(1, 4'h1, 8'hFF, "grbw_addr1");
        rd(1, 4'h2, 8'hA5, "grbw_addr2");
        rd(1, 4'h3, 8'h3C, "grbw_addr3");
        rd(1, 4'h8, 8'h22, "grbw_addr8");
        rd(1, 4'h9, 8'hDD, "grbw_addr9");
        rd(1, 4'hA, 8'hA5, "grbw_addr10");
        rd(1, 4'hB, 8'h3C, "grbw_addr11");
        rd(1, 4'hC, 8'h00, "grbw_addr12");
        rd(1, 4'hF, 8'h11, "grbw_status");

        // Every expected forwarded pulse must have appeared
        repeat (4) tick();
        checks++;
        if (pulse_q_a.size() != 0) begin
            errors++;
            $display("FAIL dout0_missing: %0d pulses not seen, expected 0", pulse_q_a.size());
        end
        checks++;
        if (pulse_q_b.size() != 0) begin
            errors++;
            $display("FAIL dout1_missing: %0d pulses not seen, expected 0", pulse_q_b.size());
        end
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d reads pending, expected 0", rd_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
